// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg
//   Shared definitions for the stream-to-memory loader: FSM state encoding,
//   header size and the number of byte lanes in a memory word.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Header is BASE (4 bytes) then LEN (4 bytes), both little-endian.
  localparam int HDR_BYTES = 8;
  // Byte lanes per 32-bit memory word.
  localparam int LANES = 4;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// mem_loader_byte_packer
//   Gathers bytes into a little-endian 32-bit word. The outputs already
//   include the byte presented this cycle, so the owner can register a
//   complete word on the same edge that accepts its last byte.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   data_byte  - byte to place
//   lane       - destination lane (0 = bits 7:0)
//   valid      - data_byte is to be merged this cycle
//   clear      - drop the accumulated word (wins over valid for the register)
//   word       - accumulated word merged with the current byte, empty lanes 0
//   mask       - lanes filled since the last clear, including the current byte
module mem_loader_byte_packer
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_byte,
  input  logic [1:0]  lane,
  input  logic        valid,
  input  logic        clear,
  output logic [31:0] word,
  output logic [3:0]  mask
);

  logic [31:0] acc;
  logic [3:0]  acc_mask;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic hit;
      assign hit                = valid && (lane == 2'(gi));
      assign word[8*gi +: 8]    = hit ? data_byte : acc[8*gi +: 8];
      assign mask[gi]           = hit | acc_mask[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      acc_mask <= '0;
    end else if (clear) begin
      // The word is being emitted (or a new transfer starts): begin empty.
      acc      <= '0;
      acc_mask <= '0;
    end else if (valid) begin
      acc      <= word;
      acc_mask <= mask;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader
//   Loads a memory from a byte stream. The stream is an 8-byte header
//   (BASE byte address, LEN byte count, both little-endian) followed by LEN
//   payload bytes, packed little-endian into 32-bit words and written through
//   a synchronous write port with per-byte enables.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - pulse to begin a transfer (only acted on while idle)
//   in_data   - stream byte, in_valid qualifies it, in_ready accepts it
//   mem_addr  - word write address
//   mem_din   - write data
//   mem_we    - byte-lane write enables, high for one cycle per word
//   busy      - transfer in progress
//   done      - one-cycle pulse at end of transfer
//   err       - sticky: misaligned BASE or a write beyond DEPTH
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t      state;
  logic [2:0]  hdr_cnt;
  logic [31:0] base;
  logic [31:0] len;
  logic [31:0] byte_cnt;
  logic [31:0] word_idx;

  logic                  accept;
  logic                  data_accept;
  logic                  last;
  logic                  emit;
  logic                  misaligned;
  logic [31:0]           word_full;
  logic                  out_of_range;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [31:0]           pk_word;
  logic [3:0]            pk_mask;

  assign accept      = in_valid & in_ready;
  assign data_accept = accept && (state == S_DATA);
  assign last        = (byte_cnt + 32'd1) == len;
  // A word goes out when its top lane fills or the stream ends mid-word.
  assign emit        = data_accept && ((byte_cnt[1:0] == 2'd3) || last);
  assign misaligned  = |base[1:0];
  // Range check uses the unwrapped address; the port address wraps.
  assign word_full    = {2'b00, base[31:2]} + word_idx;
  assign out_of_range = word_full >= 32'(DEPTH);
  assign word_addr    = base[ADDR_WIDTH+1:2] + word_idx[ADDR_WIDTH-1:0];

  mem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .data_byte (in_data),
    .lane      (byte_cnt[1:0]),
    .valid     (data_accept),
    .clear     (emit || (state == S_IDLE && start)),
    .word      (pk_word),
    .mask      (pk_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hdr_cnt  <= '0;
      base     <= '0;
      len      <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      in_ready <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_we <= '0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HDR;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            err      <= 1'b0;
            hdr_cnt  <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
          end
        end

        S_HDR: begin
          if (accept) begin
            if (!hdr_cnt[2]) base[{hdr_cnt[1:0], 3'b000} +: 8] <= in_data;
            else             len[{hdr_cnt[1:0], 3'b000} +: 8]  <= in_data;
            hdr_cnt <= hdr_cnt + 3'd1;
            // Misalignment is known from the first BASE byte.
            if (hdr_cnt == 3'd0 && in_data[1:0] != 2'b00) err <= 1'b1;
            if (hdr_cnt == 3'(HDR_BYTES - 1)) begin
              if ({in_data, len[23:0]} == 32'd0) begin
                state    <= S_DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 32'd1;
            if (emit) begin
              mem_din  <= pk_word;
              mem_addr <= word_addr;
              word_idx <= word_idx + 32'd1;
              if (out_of_range) err <= 1'b1;
              if (!out_of_range && !misaligned) mem_we <= pk_mask;
            end
            if (last) begin
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end

        S_FLUSH: begin
          // Final word is on the port this cycle.
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
